seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  - Clocked, parametrised-width successor to the combinational datapath ALU.
//  - Registered result behind a valid/ready handshake on both input and output.
//  - Adds SRA plus iterative unsigned multiply, divide and remainder
//    (MULU/DIVU/REMU), so the multi-cycle core can run M-class ops.
//  - Sits between decode/operand-read and the writeback stage.
// PARAMETERS
//  - WIDTH  32  operand/result width in bits; >= 4 and a power of 2
//  - SHW    5   shift-amount width; must equal log2(WIDTH)
// PORTS
//  - clk        in   1      clock; all state updates on the rising edge
//  - rst_n      in   1      asynchronous, active-low reset
//  - in_valid   in   1      op_A, op_B and ctrl are valid
//  - in_ready   out  1      block accepts an operation this cycle
//  - op_A       in   WIDTH  operand A (dividend, shift source)
//  - op_B       in   WIDTH  operand B (divisor; shift amount is op_B[SHW-1:0])
//  - ctrl       in   4      operation code, see BEHAVIOUR
//  - out_valid  out  1      res and the flag outputs hold a completed result
//  - out_ready  in   1      consumer takes the result this cycle
//  - res        out  WIDTH  result
//  - carry      out  1      ADD: carry out of the MSB; SUB: carry out of A+~B+1; else 0
//  - overflow   out  1      signed overflow, ADD/SUB only; else 0
//  - zero       out  1      res == 0, for every op
//  - div_zero   out  1      1 when DIVU/REMU ran with op_B == 0; else 0
// BEHAVIOUR
//  - Opcodes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLTU 0101, SUB 0110,
//    SLT 0111, SLL 1000, SRL 1001, SRA 1011, MULU 1100, DIVU 1110, REMU 1111.
//  - Unused opcodes (0100, 1010, 1101): res = 0, all flags 0, 1-cycle latency.
//  - SLT/SLTU: res = {0..0, A<B}, signed or unsigned compare respectively;
//    the signed compare is correct even when A-B overflows.
//  - Reset: state = IDLE; out_valid = 0; res, carry, overflow, div_zero = 0;
//    zero = 1 (since res = 0); in_ready follows its rule below. Any in-flight
//    operation is discarded.
//  - Handshake: a transfer occurs on a clock edge where valid && ready.
//    in_ready = (state == IDLE) && (!out_valid || out_ready).
//  - While out_valid && !out_ready, res and all flags stay stable.
//  - FSM IDLE: accepting a single-cycle op registers its result, and out_valid = 1
//    on the next cycle. Throughput is 1 op/cycle with back-to-back accept;
//    a same-cycle out handshake plus in accept replaces the result.
//  - FSM IDLE -> MUL on accepting MULU; IDLE -> DIV on accepting DIVU/REMU.
//    On that accept, out_valid falls if the old result handshook, otherwise it stays high.
//  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles. res is the low
//    WIDTH bits of the product; then MUL -> IDLE with out_valid = 1.
//    Accept-to-out_valid latency is WIDTH+1 cycles.
//  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles.
//    DIVU gives the quotient, REMU the remainder; latency is WIDTH+1 cycles.
//  - Divide by zero (op_B == 0): no iteration. DIVU res = all ones; REMU res = op_A;
//    div_zero = 1; latency 1 cycle; FSM stays in IDLE.
//  - Operands are captured at accept; later changes on the inputs have no effect.
//  - Async reset asserted in MUL or DIV: the op is aborted and no result is produced.
// CONFIGURATION
//  - SEQ_ALU_MULDIV_EN defined: MULU/DIVU/REMU, the MUL/DIV states and the
//    div_zero logic are built as described above.
//  - SEQ_ALU_MULDIV_EN undefined: 1100/1110/1111 are treated as unused opcodes
//    (res = 0, 1 cycle); div_zero is tied to 0; the FSM has only IDLE.
//    All other behaviour and latencies are unchanged.
// TESTING
//  - ADD, 0x7FFFFFFF + 1 -> res 0x80000000, overflow 1, carry 0.
//    SUB, 5 - 5 -> res 0, zero 1, carry 1.
//  - SLT, A = 0x80000000, B = 1 -> res 1; SLTU same operands -> res 0.
//    SRA, 0xF0000000 by 4 -> res 0xFF000000.
//  - Back-to-back ADDs with out_ready held at 1 -> one result per cycle, in order.
//    Holding out_ready at 0 for 3 cycles -> in_ready = 0 and res stable.
//  - MULU, 0x0001_0003 * 0x0002_0005 -> res 0x000B_000F, out_valid 33 cycles after accept.
//    DIVU 100/7 -> res 14; REMU 100/7 -> res 2.
//  - DIVU 9/0 -> res 0xFFFFFFFF, div_zero 1, 1-cycle latency. REMU 9/0 -> res 9.
//  - rst_n pulsed low mid-MULU -> out_valid 0 and in_ready 1 after release.
//    Rebuild without SEQ_ALU_MULDIV_EN: MULU -> res 0 after 1 cycle.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: operation request channel and registered result channel.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_A;
    logic [WIDTH-1:0] op_B;
    logic [3:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             div_zero;

    modport master (
        output in_valid, op_A, op_B, ctrl, out_ready,
        input  in_ready, out_valid, res, carry, overflow, zero, div_zero
    );

    modport slave (
        input  in_valid, op_A, op_B, ctrl, out_ready,
        output in_ready, out_valid, res, carry, overflow, zero, div_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes and a registered result/flag set.
// Define SEQ_ALU_MULDIV_EN to build the iterative MULU/DIVU/REMU unit.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
`endif

    logic [1:0]       state_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             out_hs_s;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SHW-1:0]   sh_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_carry_s;
    logic             alu_ovf_s;
    logic             alu_zero_s;

`ifdef SEQ_ALU_MULDIV_EN
    logic             div_zero_r;
    logic             alu_dz_s;
    logic             start_mul_s;
    logic             start_div_s;

    // acc holds the partial product or the partial remainder; opx holds the
    // multiplicand or divisor; opy holds the multiplier or the dividend that
    // is shifted out while quotient bits are shifted in.
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] opx_r;
    logic [WIDTH-1:0] opy_r;
    logic [SHW-1:0]   cnt_r;
    logic             is_rem_r;

    logic [WIDTH:0]   trial_s;
    logic             ge_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] opx_nxt_s;
    logic [WIDTH-1:0] opy_nxt_s;
    logic [WIDTH-1:0] fin_res_s;
    logic             last_s;
    logic             step_en_s;
`endif

    assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign out_hs_s   = out_valid_r && bus.out_ready;

    // Single-cycle result and flags for the operation presented on the inputs.
    always_comb begin
        sum_s       = {1'b0, bus.op_A} + {1'b0, bus.op_B};
        diff_s      = {1'b0, bus.op_A} + {1'b0, ~bus.op_B} + {{WIDTH{1'b0}}, 1'b1};
        sh_s        = bus.op_B[SHW-1:0];
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
        alu_dz_s    = 1'b0;
        start_mul_s = 1'b0;
        start_div_s = 1'b0;
`endif
        case (bus.ctrl)
            OP_AND:  alu_res_s = bus.op_A & bus.op_B;
            OP_OR:   alu_res_s = bus.op_A | bus.op_B;
            OP_XOR:  alu_res_s = bus.op_A ^ bus.op_B;
            OP_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (bus.op_A[WIDTH-1] == bus.op_B[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != bus.op_A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[WIDTH-1:0];
                alu_carry_s = diff_s[WIDTH];
                alu_ovf_s   = (bus.op_A[WIDTH-1] != bus.op_B[WIDTH-1]) &&
                              (diff_s[WIDTH-1] != bus.op_A[WIDTH-1]);
            end
            // Direct signed compare stays correct when A-B would overflow.
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.op_A) < $signed(bus.op_B))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.op_A < bus.op_B)};
            OP_SLL:  alu_res_s = bus.op_A << sh_s;
            OP_SRL:  alu_res_s = bus.op_A >> sh_s;
            OP_SRA:  alu_res_s = $unsigned($signed(bus.op_A) >>> sh_s);
`ifdef SEQ_ALU_MULDIV_EN
            OP_MULU: start_mul_s = 1'b1;
            OP_DIVU, OP_REMU: begin
                if (bus.op_B == {WIDTH{1'b0}}) begin
                    alu_dz_s  = 1'b1;
                    alu_res_s = (bus.ctrl == OP_DIVU) ? {WIDTH{1'b1}} : bus.op_A;
                end else begin
                    start_div_s = 1'b1;
                end
            end
`endif
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign alu_zero_s = (alu_res_s == {WIDTH{1'b0}});

`ifdef SEQ_ALU_MULDIV_EN
    assign last_s = (cnt_r == CNT_LAST);
    // The final iteration writes the result, so it waits while an older
    // result is still held for the consumer.
    assign step_en_s = (state_r != ST_IDLE) && (!last_s || !out_valid_r || bus.out_ready);

    // One shift-add or one restoring-division step.
    always_comb begin
        trial_s = {acc_r, opy_r[WIDTH-1]};
        ge_s    = (trial_s >= {1'b0, opx_r});
        if (state_r == ST_MUL) begin
            acc_nxt_s = acc_r + (opy_r[0] ? opx_r : {WIDTH{1'b0}});
            opx_nxt_s = {opx_r[WIDTH-2:0], 1'b0};
            opy_nxt_s = {1'b0, opy_r[WIDTH-1:1]};
        end else begin
            acc_nxt_s = ge_s ? (trial_s[WIDTH-1:0] - opx_r) : trial_s[WIDTH-1:0];
            opx_nxt_s = opx_r;
            opy_nxt_s = {opy_r[WIDTH-2:0], ge_s};
        end
        if ((state_r == ST_DIV) && !is_rem_r) begin
            fin_res_s = opy_nxt_s;
        end else begin
            fin_res_s = acc_nxt_s;
        end
    end

    // Iterative multiply/divide working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {WIDTH{1'b0}};
            opx_r    <= {WIDTH{1'b0}};
            opy_r    <= {WIDTH{1'b0}};
            cnt_r    <= {SHW{1'b0}};
            is_rem_r <= 1'b0;
        end else if (accept_s && start_mul_s) begin
            acc_r    <= {WIDTH{1'b0}};
            opx_r    <= bus.op_A;
            opy_r    <= bus.op_B;
            cnt_r    <= {SHW{1'b0}};
            is_rem_r <= 1'b0;
        end else if (accept_s && start_div_s) begin
            acc_r    <= {WIDTH{1'b0}};
            opx_r    <= bus.op_B;
            opy_r    <= bus.op_A;
            cnt_r    <= {SHW{1'b0}};
            is_rem_r <= (bus.ctrl == OP_REMU);
        end else if (step_en_s) begin
            acc_r    <= acc_nxt_s;
            opx_r    <= opx_nxt_s;
            opy_r    <= opy_nxt_s;
            cnt_r    <= cnt_r + CNT_ONE;
        end
    end
`endif

    // Control FSM, output valid and the registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            res_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b1;
`ifdef SEQ_ALU_MULDIV_EN
            div_zero_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
`ifdef SEQ_ALU_MULDIV_EN
                    if (accept_s && start_mul_s) begin
                        state_r     <= ST_MUL;
                        out_valid_r <= out_valid_r && !bus.out_ready;
                    end else if (accept_s && start_div_s) begin
                        state_r     <= ST_DIV;
                        out_valid_r <= out_valid_r && !bus.out_ready;
                    end else
`endif
                    if (accept_s) begin
                        out_valid_r <= 1'b1;
                        res_r       <= alu_res_s;
                        carry_r     <= alu_carry_s;
                        overflow_r  <= alu_ovf_s;
                        zero_r      <= alu_zero_s;
`ifdef SEQ_ALU_MULDIV_EN
                        div_zero_r  <= alu_dz_s;
`endif
                    end else if (out_hs_s) begin
                        out_valid_r <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    if (step_en_s && last_s) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b1;
                        res_r       <= fin_res_s;
                        carry_r     <= 1'b0;
                        overflow_r  <= 1'b0;
                        zero_r      <= (fin_res_s == {WIDTH{1'b0}});
                        div_zero_r  <= 1'b0;
                    end else if (out_hs_s) begin
                        out_valid_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.res       = res_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
`ifdef SEQ_ALU_MULDIV_EN
    assign bus.div_zero  = div_zero_r;
`else
    assign bus.div_zero  = 1'b0;
`endif
endmodule
